frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader.sv | 205 ++++++++++++++++++++
 tb/tb_frame_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : frame_reader
// Description : Streams a stored RGB frame out of byte-wide memory. Each
//               pixel needs three reads (R, G, B) and is then held on a
//               valid/ready interface until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_reader #(
    parameter int p_H_RES  = 640,
    parameter int p_V_RES  = 480,
    parameter int p_ADDR_W = 20
) (
    input  logic                i_CLK,
    input  logic                i_RST_N,
    input  logic                i_ENABLE,
    input  logic [1:0]          i_IMAGE_SELECT,
    output logic [1:0]          o_IMAGE_SEL,
    output logic [p_ADDR_W-1:0] o_MEM_ADDR,
    output logic                o_MEM_RD,
    input  logic [7:0]          i_MEM_DATA,
    output logic [23:0]         o_PIXEL,
    output logic                o_PIXEL_VALID,
    input  logic                i_PIXEL_READY,
    output logic                o_SOF,
    output logic                o_EOL
);

    localparam int c_X_W = (p_H_RES > 1) ? $clog2(p_H_RES) : 1;
    localparam int c_Y_W = (p_V_RES > 1) ? $clog2(p_V_RES) : 1;

    localparam logic [c_X_W-1:0]    c_X_LAST   = c_X_W'(p_H_RES - 1);
    localparam logic [c_Y_W-1:0]    c_Y_LAST   = c_Y_W'(p_V_RES - 1);
    localparam logic [p_ADDR_W-1:0] c_ADDR_1   = p_ADDR_W'(1);
    localparam logic [p_ADDR_W-1:0] c_ADDR_2   = p_ADDR_W'(2);
    localparam logic [p_ADDR_W-1:0] c_ADDR_3   = p_ADDR_W'(3);
    localparam logic [1:0]          c_SEL_NONE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_R = 3'd1,
        S_FETCH_G = 3'd2,
        S_FETCH_B = 3'd3,
        S_CAPTURE = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sel_q,   sel_d;
    logic [p_ADDR_W-1:0]   base_q,  base_d;   // address of the current pixel's R byte
    logic [p_ADDR_W-1:0]   addr_q,  addr_d;
    logic                  rd_q,    rd_d;
    logic [c_X_W-1:0]      x_q,     x_d;
    logic [c_Y_W-1:0]      y_q,     y_d;
    logic [7:0]            red_q,   red_d;
    logic [7:0]            grn_q,   grn_d;
    logic [23:0]           pixel_q, pixel_d;
    logic                  valid_q, valid_d;
    logic                  sof_q,   sof_d;
    logic                  eol_q,   eol_d;

    logic w_no_img;
    logic w_handshake;
    logic w_last_pix;

    assign w_no_img    = (sel_q == c_SEL_NONE);
    assign w_handshake = valid_q & i_PIXEL_READY;
    assign w_last_pix  = (x_q == c_X_LAST) && (y_q == c_Y_LAST);

    // Next-state and next-output computation for the fetch/hold sequencer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        base_d  = base_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        x_d     = x_q;
        y_d     = y_q;
        red_d   = red_q;
        grn_d   = grn_q;
        pixel_d = pixel_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eol_d   = eol_q;

        case (state_q)
            S_IDLE: begin
                if (i_ENABLE) begin
                    sel_d   = i_IMAGE_SELECT;
                    base_d  = '0;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    rd_d    = (i_IMAGE_SELECT != c_SEL_NONE);
                    state_d = S_FETCH_R;
                end
            end
            S_FETCH_R: begin
                addr_d  = base_q + c_ADDR_1;
                rd_d    = ~w_no_img;
                state_d = S_FETCH_G;
            end
            S_FETCH_G: begin
                red_d   = i_MEM_DATA;
                addr_d  = base_q + c_ADDR_2;
                rd_d    = ~w_no_img;
                state_d = S_FETCH_B;
            end
            S_FETCH_B: begin
                grn_d   = i_MEM_DATA;
                rd_d    = 1'b0;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                pixel_d = w_no_img ? 24'h000000 : {red_q, grn_q, i_MEM_DATA};
                valid_d = 1'b1;
                sof_d   = (x_q == '0) && (y_q == '0);
                eol_d   = (x_q == c_X_LAST);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (w_handshake) begin
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eol_d   = 1'b0;
                    if (w_last_pix) begin
                        // Frame complete: rewind and either restart or park.
                        base_d = '0;
                        x_d    = '0;
                        y_d    = '0;
                        if (i_ENABLE) begin
                            sel_d   = i_IMAGE_SELECT;
                            addr_d  = '0;
                            rd_d    = (i_IMAGE_SELECT != c_SEL_NONE);
                            state_d = S_FETCH_R;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        base_d  = base_q + c_ADDR_3;
                        addr_d  = base_q + c_ADDR_3;
                        rd_d    = ~w_no_img;
                        state_d = S_FETCH_R;
                        if (x_q == c_X_LAST) begin
                            x_d = '0;
                            y_d = y_q + c_Y_W'(1);
                        end else begin
                            x_d = x_q + c_X_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b0;
                valid_d = 1'b0;
                sof_d   = 1'b0;
                eol_d   = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs, cleared asynchronously.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            base_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            red_q   <= 8'd0;
            grn_q   <= 8'd0;
            pixel_q <= 24'd0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign o_IMAGE_SEL   = sel_q;
    assign o_MEM_ADDR    = addr_q;
    assign o_MEM_RD      = rd_q;
    assign o_PIXEL       = pixel_q;
    assign o_PIXEL_VALID = valid_q;
    assign o_SOF         = sof_q;
    assign o_EOL         = eol_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_reader
// Description : Self-checking bench for frame_reader on a 4x2 frame with a
//               behavioural memory and pixel-sequence reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_reader;

    localparam int c_H  = 4;
    localparam int c_V  = 2;
    localparam int c_AW = 8;
    localparam int c_N  = c_H * c_V;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_ENABLE = 1'b0;
    logic [1:0]      i_IMAGE_SELECT = 2'd0;
    logic [1:0]      o_IMAGE_SEL;
    logic [c_AW-1:0] o_MEM_ADDR;
    logic            o_MEM_RD;
    logic [7:0]      mem_data;
    logic [23:0]     o_PIXEL;
    logic            o_PIXEL_VALID;
    logic            i_PIXEL_READY = 1'b0;
    logic            o_SOF;
    logic            o_EOL;

    int passed = 0;
    int total  = 0;

    int rd_count     = 0;
    int last_rd_addr = -1;
    int max_rd_addr  = -1;

    frame_reader #(
        .p_H_RES (c_H),
        .p_V_RES (c_V),
        .p_ADDR_W(c_AW)
    ) u_dut (
        .i_CLK         (clk),
        .i_RST_N       (rst_n),
        .i_ENABLE      (i_ENABLE),
        .i_IMAGE_SELECT(i_IMAGE_SELECT),
        .o_IMAGE_SEL   (o_IMAGE_SEL),
        .o_MEM_ADDR    (o_MEM_ADDR),
        .o_MEM_RD      (o_MEM_RD),
        .i_MEM_DATA    (mem_data),
        .o_PIXEL       (o_PIXEL),
        .o_PIXEL_VALID (o_PIXEL_VALID),
        .i_PIXEL_READY (i_PIXEL_READY),
        .o_SOF         (o_SOF),
        .o_EOL         (o_EOL)
    );

    always #5 clk = ~clk;

    // Stored image contents: byte at address a of image s.
    function automatic logic [7:0] img_byte(input logic [1:0] s, input int a);
        logic [7:0] key;
        case (s)
            2'd0:    key = 8'h3C;
            2'd1:    key = 8'h00;
            2'd2:    key = 8'hA5;
            default: key = 8'h77;
        endcase
        return 8'(a) ^ key;
    endfunction

    // Expected k-th pixel of a frame from image s.
    function automatic logic [23:0] exp_pixel(input logic [1:0] s, input int k);
        if (s == 2'd3) return 24'h000000;
        return {img_byte(s, 3*k), img_byte(s, 3*k+1), img_byte(s, 3*k+2)};
    endfunction

    // Synchronous-read memory behind the image multiplexer.
    always @(posedge clk)
        mem_data <= o_MEM_RD ? img_byte(o_IMAGE_SEL, int'(o_MEM_ADDR)) : 8'hEE;

    // Read-strobe observer.
    always @(negedge clk) begin
        if (o_MEM_RD === 1'b1) begin
            rd_count++;
            last_rd_addr = int'(o_MEM_ADDR);
            if (int'(o_MEM_ADDR) > max_rd_addr) max_rd_addr = int'(o_MEM_ADDR);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_ENABLE = 1'b1;
        i_IMAGE_SELECT = 2'd2;
        step(); step(); step();
        total++; if (o_MEM_RD !== 1'b0) $display("FAIL reset_rd got %b want 0", o_MEM_RD); else passed++;
        total++; if (o_MEM_ADDR !== '0) $display("FAIL reset_addr got %h want 0", o_MEM_ADDR); else passed++;
        total++; if (o_PIXEL !== 24'h0) $display("FAIL reset_pixel got %h want 000000", o_PIXEL); else passed++;
        total++; if (o_PIXEL_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", o_PIXEL_VALID); else passed++;
        total++; if ({o_SOF, o_EOL} !== 2'b00) $display("FAIL reset_sof_eol got %b want 00", {o_SOF, o_EOL}); else passed++;
        total++; if (o_IMAGE_SEL !== 2'd0) $display("FAIL reset_sel got %0d want 0", o_IMAGE_SEL); else passed++;
        i_ENABLE = 1'b0;
        rst_n = 1'b1;
        step(); step();
        total++; if (o_MEM_RD !== 1'b0 || o_PIXEL_VALID !== 1'b0)
            $display("FAIL idle_quiet got rd=%b valid=%b want 0 0", o_MEM_RD, o_PIXEL_VALID); else passed++;
    endtask

    // Leave IDLE with the given select; called at a sample point while idle.
    task automatic start_frame(input logic [1:0] s);
        i_IMAGE_SELECT = s;
        i_ENABLE = 1'b1;
        step();
        total++; if (o_IMAGE_SEL !== s) $display("FAIL start_sel got %0d want %0d", o_IMAGE_SEL, s); else passed++;
        total++; if (o_MEM_ADDR !== '0) $display("FAIL start_addr got %0d want 0", o_MEM_ADDR); else passed++;
        total++; if (o_MEM_RD !== (s != 2'd3)) $display("FAIL start_rd got %b want %b", o_MEM_RD, (s != 2'd3)); else passed++;
    endtask

    // Wait for pixel k, optionally stall it for lo cycles, then accept it.
    task automatic get_pixel(input int k, input logic [1:0] s, input int lo, output int wait_c);
        int rd0;
        wait_c = 0;
        i_PIXEL_READY = 1'b0;
        while (o_PIXEL_VALID !== 1'b1 && wait_c < 40) begin
            step();
            wait_c++;
        end
        total++;
        if (o_PIXEL_VALID !== 1'b1) begin
            $display("FAIL valid_timeout pixel=%0d got no valid after %0d cycles want valid", k, wait_c);
            return;
        end
        passed++;
        rd0 = rd_count;
        for (int c = 0; c <= lo; c++) begin
            total++; if (o_PIXEL !== exp_pixel(s, k))
                $display("FAIL pixel k=%0d cyc=%0d got %h want %h", k, c, o_PIXEL, exp_pixel(s, k)); else passed++;
            total++; if (o_SOF !== (k == 0))
                $display("FAIL sof k=%0d cyc=%0d got %b want %b", k, c, o_SOF, (k == 0)); else passed++;
            total++; if (o_EOL !== ((k % c_H) == c_H - 1))
                $display("FAIL eol k=%0d cyc=%0d got %b want %b", k, c, o_EOL, ((k % c_H) == c_H - 1)); else passed++;
            total++; if (o_PIXEL_VALID !== 1'b1 || o_MEM_RD !== 1'b0)
                $display("FAIL hold_state k=%0d cyc=%0d got valid=%b rd=%b want 1 0", k, c, o_PIXEL_VALID, o_MEM_RD); else passed++;
            total++; if (int'(o_MEM_ADDR) !== 3*k + 2)
                $display("FAIL hold_addr k=%0d cyc=%0d got %0d want %0d", k, c, o_MEM_ADDR, 3*k + 2); else passed++;
            if (c < lo) step();
        end
        if (lo > 0) begin
            total++; if (rd_count !== rd0)
                $display("FAIL stall_reads k=%0d got %0d want %0d", k, rd_count - rd0, 0); else passed++;
        end
        i_PIXEL_READY = 1'b1;
        step();
        i_PIXEL_READY = 1'b0;
        total++; if (o_PIXEL_VALID !== 1'b0)
            $display("FAIL accept k=%0d got valid=%b want 0", k, o_PIXEL_VALID); else passed++;
    endtask

    // Consume one full frame from image s and check it against the model.
    task automatic run_frame(input logic [1:0] s, input bit stalls, input int stall_k,
                             input bit en_end, input logic [1:0] next_sel, input bit mid_change);
        int w;
        int lo;
        for (int k = 0; k < c_N; k++) begin
            lo = stalls ? int'($urandom_range(0, 3)) : 0;
            if (k == stall_k) lo = 10;
            if (mid_change && k == 1) begin
                i_ENABLE = 1'b0;
                i_IMAGE_SELECT = next_sel;
            end
            if (k == c_N - 1) begin
                i_ENABLE = en_end;
                i_IMAGE_SELECT = next_sel;
            end
            get_pixel(k, s, lo, w);
            if (!stalls) begin
                total++; if (w !== 4) $display("FAIL pixel_latency k=%0d got %0d want 4", k, w); else passed++;
            end
            if (k < c_N - 1) begin
                total++; if (o_IMAGE_SEL !== s)
                    $display("FAIL sel_stable k=%0d got %0d want %0d", k, o_IMAGE_SEL, s); else passed++;
            end
        end
        if (s != 2'd3) begin
            total++; if (last_rd_addr !== 3*c_N - 1)
                $display("FAIL last_read got %0d want %0d", last_rd_addr, 3*c_N - 1); else passed++;
        end
        total++; if (o_IMAGE_SEL !== (en_end ? next_sel : s))
            $display("FAIL frame_end_sel got %0d want %0d", o_IMAGE_SEL, (en_end ? next_sel : s)); else passed++;
        if (en_end) begin
            total++; if (o_MEM_ADDR !== '0 || o_MEM_RD !== (next_sel != 2'd3))
                $display("FAIL wrap got addr=%0d rd=%b want 0 %b", o_MEM_ADDR, o_MEM_RD, (next_sel != 2'd3)); else passed++;
        end
    endtask

    // After a frame ends with enable low: nothing moves, address is held.
    task automatic check_idle();
        int rd0;
        rd0 = rd_count;
        for (int c = 0; c < 8; c++) begin
            total++; if (o_PIXEL_VALID !== 1'b0 || o_MEM_RD !== 1'b0)
                $display("FAIL idle c=%0d got valid=%b rd=%b want 0 0", c, o_PIXEL_VALID, o_MEM_RD); else passed++;
            step();
        end
        total++; if (rd_count !== rd0) $display("FAIL idle_reads got %0d want 0", rd_count - rd0); else passed++;
        total++; if (int'(o_MEM_ADDR) !== 3*c_N - 1)
            $display("FAIL idle_addr got %0d want %0d", o_MEM_ADDR, 3*c_N - 1); else passed++;
    endtask

    task automatic test_first_pixel();
        start_frame(2'd1);
        run_frame(2'd1, 1'b0, -1, 1'b1, 2'd1, 1'b0);
    endtask

    task automatic test_frame_wrap_and_stall();
        run_frame(2'd1, 1'b0, -1, 1'b1, 2'd1, 1'b0);
        run_frame(2'd1, 1'b0, 5, 1'b0, 2'd1, 1'b0);
        check_idle();
    endtask

    task automatic test_enable_drop();
        start_frame(2'd0);
        run_frame(2'd0, 1'b0, -1, 1'b0, 2'd2, 1'b1);
        check_idle();
    endtask

    task automatic test_no_image();
        int rd0;
        rd0 = rd_count;
        start_frame(2'd3);
        run_frame(2'd3, 1'b0, -1, 1'b0, 2'd3, 1'b0);
        total++; if (rd_count !== rd0) $display("FAIL no_image_reads got %0d want 0", rd_count - rd0); else passed++;
        check_idle();
    endtask

    task automatic test_reset_mid_frame();
        start_frame(2'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        total++; if (o_MEM_RD !== 1'b0 || o_MEM_ADDR !== '0)
            $display("FAIL async_reset_mem got rd=%b addr=%0d want 0 0", o_MEM_RD, o_MEM_ADDR); else passed++;
        total++; if (o_IMAGE_SEL !== 2'd0 || o_PIXEL_VALID !== 1'b0 || o_PIXEL !== 24'h0)
            $display("FAIL async_reset_out got sel=%0d valid=%b pix=%h want 0 0 000000", o_IMAGE_SEL, o_PIXEL_VALID, o_PIXEL); else passed++;
        i_IMAGE_SELECT = 2'd2;
        i_ENABLE = 1'b1;
        #1 rst_n = 1'b1;
        step();
        total++; if (o_MEM_RD !== 1'b1 || o_MEM_ADDR !== '0 || o_IMAGE_SEL !== 2'd2)
            $display("FAIL restart got rd=%b addr=%0d sel=%0d want 1 0 2", o_MEM_RD, o_MEM_ADDR, o_IMAGE_SEL); else passed++;
        run_frame(2'd2, 1'b0, -1, 1'b0, 2'd2, 1'b0);
        check_idle();
    endtask

    task automatic test_random_stream();
        logic [1:0] s;
        logic [1:0] ns;
        s = 2'($urandom_range(0, 3));
        start_frame(s);
        for (int f = 0; f < 4; f++) begin
            ns = 2'($urandom_range(0, 3));
            run_frame(s, 1'b1, -1, (f < 3), ns, 1'b0);
            if (f < 3) s = ns;
        end
        check_idle();
        total++; if (max_rd_addr > 3*c_N - 1)
            $display("FAIL max_addr got %0d want <= %0d", max_rd_addr, 3*c_N - 1); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_frame_wrap_and_stall();
        test_enable_drop();
        test_no_image();
        test_reset_mid_frame();
        test_random_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
